// File: rtl/inst_rom_loader.sv
// rtl/inst_rom_loader.sv - byte-stream instruction ROM loader with core reset sequencing
//
// Purpose:
//   Receives a program as a byte stream and writes it into an internal
//   instruction memory. The stream is a 16-bit big-endian word count N,
//   followed by N big-endian 32-bit words. The core is held in reset until
//   the whole program is in memory, and is then released to fetch from it.
//   An optional trailing checksum byte (modulo-256 sum of the header and data
//   bytes) is enabled by defining the macro LOADER_CHECKSUM_EN.
//
// Parameters:
//   DEPTH_LOG2  log2 of the instruction-word capacity
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous active-low reset
//   ce          core fetch enable
//   addr[31:0]  core fetch byte address (bits [1:0] ignored)
//   inst[31:0]  fetched instruction, 0 (NOP) when not readable
//   load_byte   loader data byte
//   load_valid  load_byte is valid
//   load_ready  loader can accept a byte
//   reload      single-cycle request to load a new program (honoured in RUN only)
//   core_rst_n  registered active-low reset for the core
//   done        program loaded, core running
//   load_err    load failed; sticky until rst

module inst_rom_loader #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] addr,
  output logic [31:0] inst,
  input  logic [7:0]  load_byte,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        reload,
  output logic        core_rst_n,
  output logic        done,
  output logic        load_err
);

  localparam int CW = DEPTH_LOG2 + 2;
  localparam logic [16:0]         MAX_WORDS = 17'd1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] N_ONE     = 1;
  localparam logic [CW-1:0]       CNT_ONE   = 1;

  typedef enum logic [2:0] {
    S_HDR0 = 3'd0,
    S_HDR1 = 3'd1,
    S_DATA = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CHK  = 3'd3,
`endif
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // State entered once the last data byte (or an empty header) is taken.
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_LOADED = S_CHK;
`else
  localparam state_t S_LOADED = S_RUN;
`endif

  state_t                r_state;
  state_t                w_next_state;
  logic [DEPTH_LOG2:0]   r_n;
  logic [7:0]            r_hdr_hi;
  logic [23:0]           r_shift;
  logic [CW-1:0]         r_cnt;
  logic [31:0]           r_mem [0:(1<<DEPTH_LOG2)-1];
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            r_sum;
`endif

  logic                  w_accept;
  logic                  w_mem_we;
  logic                  w_word_last;
  logic                  w_last_byte;
  logic                  w_hdr_legal;
  logic [15:0]           w_hdr_n;
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic                  w_rd_hit;
  logic                  w_unused;

  assign load_ready = (r_state == S_HDR0) || (r_state == S_HDR1) ||
`ifdef LOADER_CHECKSUM_EN
                      (r_state == S_CHK) ||
`endif
                      (r_state == S_DATA);

  // Bytes presented while rst is low must never be taken.
  assign w_accept    = rst & load_valid & load_ready;
  assign w_hdr_n     = {r_hdr_hi, load_byte};
  assign w_hdr_legal = ({1'b0, w_hdr_n} <= MAX_WORDS);
  assign w_word_last = ({1'b0, r_cnt[CW-1:2]} == (r_n - N_ONE));
  assign w_last_byte = (r_cnt[1:0] == 2'b11) && w_word_last;

  always_comb begin
    w_next_state = r_state;
    w_mem_we     = 1'b0;
    case (r_state)
      S_HDR0: if (w_accept) w_next_state = S_HDR1;
      S_HDR1: begin
        if (w_accept) begin
          if (w_hdr_n == 16'h0)  w_next_state = S_LOADED;
          else if (!w_hdr_legal) w_next_state = S_ERR;
          else                   w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (w_accept && (r_cnt[1:0] == 2'b11)) begin
          w_mem_we = 1'b1;
          if (w_word_last) w_next_state = S_LOADED;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_accept) w_next_state = (load_byte == r_sum) ? S_RUN : S_ERR;
      end
`endif
      S_RUN:   if (reload) w_next_state = S_HDR0;
      S_ERR:   w_next_state = S_ERR;
      default: w_next_state = S_HDR0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_HDR0;
      r_n        <= '0;
      r_hdr_hi   <= '0;
      r_shift    <= '0;
      r_cnt      <= '0;
      core_rst_n <= 1'b0;
      done       <= 1'b0;
      load_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_state <= w_next_state;
      // Outputs follow the next state so they change together with it.
      core_rst_n <= (w_next_state == S_RUN);
      done       <= (w_next_state == S_RUN);
      load_err   <= (w_next_state == S_ERR);

      if (w_accept) begin
        case (r_state)
          S_HDR0: r_hdr_hi <= load_byte;
          S_HDR1: begin
            r_cnt <= '0;
            if (w_hdr_legal) r_n <= w_hdr_n[DEPTH_LOG2:0];
          end
          S_DATA: begin
            r_shift <= {r_shift[15:0], load_byte};
            // Return to zero after the final byte instead of wrapping.
            r_cnt   <= w_last_byte ? '0 : r_cnt + CNT_ONE;
          end
          default: ;
        endcase
`ifdef LOADER_CHECKSUM_EN
        if (r_state != S_CHK) r_sum <= r_sum + load_byte;
`endif
      end

      if ((r_state == S_RUN) && reload) begin
        r_n <= '0;
`ifdef LOADER_CHECKSUM_EN
        r_sum <= '0;
`endif
      end
    end
  end

  // Program memory is never cleared; r_n = 0 keeps old contents unreadable.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_cnt[CW-1:2]] <= {r_shift, load_byte};
  end

  assign w_rd_idx = addr[DEPTH_LOG2+1:2];
  assign w_rd_hit = (r_state == S_RUN) && ce &&
                    (addr[31:DEPTH_LOG2+2] == '0) &&
                    ({1'b0, w_rd_idx} < r_n);
  assign inst     = w_rd_hit ? r_mem[w_rd_idx] : 32'h0;

  // Byte-lane bits of the fetch address have no meaning for word fetches.
  assign w_unused = ^addr[1:0];

endmodule

// File: tb/tb_inst_rom_loader.sv
// tb/tb_inst_rom_loader.sv - self-checking bench for inst_rom_loader
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst;
  logic [7:0]  load_byte;
  logic        load_valid;
  logic        load_ready;
  logic        reload;
  logic        core_rst_n;
  logic        done;
  logic        load_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] stream_q[$];

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t tab [7];

  inst_rom_loader #(.DEPTH_LOG2(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .addr       (addr),
    .inst       (inst),
    .load_byte  (load_byte),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .reload     (reload),
    .core_rst_n (core_rst_n),
    .done       (done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    int tmo;
    g = gaps ? int'($urandom_range(0, 2)) : 0;
    repeat (g) begin
      load_valid = 1'b0;
      load_byte  = 8'($urandom);
      tick();
    end
    load_valid = 1'b1;
    load_byte  = b;
    tmo = 0;
    while (!load_ready && tmo < 20) begin
      tick();
      tmo++;
    end
    if (!load_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=load_ready_0 required=load_ready_1");
    end
    tick();
    load_valid = 1'b0;
  endtask

  // Sends stream_q (plus checksum when enabled); expects RUN after last byte.
  task automatic run_stream(input string tag, input bit gaps);
    logic [7:0] sum;
    sum = 8'h0;
    foreach (stream_q[i]) sum = sum + stream_q[i];
`ifdef LOADER_CHECKSUM_EN
    stream_q.push_back(sum);
`endif
    for (int i = 0; i < stream_q.size() - 1; i++) send_byte(stream_q[i], gaps);
    chk({tag, "_pre_rstn"}, {31'b0, core_rst_n}, 32'h0);
    send_byte(stream_q[stream_q.size() - 1], gaps);
    chk({tag, "_rstn"},  {31'b0, core_rst_n}, 32'h1);
    chk({tag, "_done"},  {31'b0, done},       32'h1);
    chk({tag, "_ready"}, {31'b0, load_ready}, 32'h0);
  endtask

  task automatic pulse_reload(input logic [7:0] b);
    reload     = 1'b1;
    load_valid = 1'b1;
    load_byte  = b;
    tick();
    reload     = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    ce   = 1'b1;
    addr = a;
    #1;
    chk(name, inst, exp);
  endtask

  initial begin
    int bad;
    tab[0] = '{ce: 1'b1, addr: 32'h0000_0000, exp: 32'h2401_0005};
    tab[1] = '{ce: 1'b1, addr: 32'h0000_0004, exp: 32'h0000_0000};
    tab[2] = '{ce: 1'b1, addr: 32'h0000_0008, exp: 32'h0000_0000};
    tab[3] = '{ce: 1'b1, addr: 32'h0000_0003, exp: 32'h2401_0005};
    tab[4] = '{ce: 1'b0, addr: 32'h0000_0000, exp: 32'h0000_0000};
    tab[5] = '{ce: 1'b1, addr: 32'h0001_0000, exp: 32'h0000_0000};
    tab[6] = '{ce: 1'b1, addr: 32'h0000_1000, exp: 32'h0000_0000};

    // Reset with a byte offered: nothing may be accepted.
    rst = 1'b0; ce = 1'b1; addr = 32'h0; reload = 1'b0;
    load_valid = 1'b1; load_byte = 8'h55;
    repeat (3) tick();
    chk("rst_ready", {31'b0, load_ready}, 32'h1);
    chk("rst_rstn",  {31'b0, core_rst_n}, 32'h0);
    chk("rst_done",  {31'b0, done},       32'h0);
    chk("rst_err",   {31'b0, load_err},   32'h0);
    chk("rst_inst",  inst,                32'h0);
    load_valid = 1'b0;
    rst = 1'b1;
    tick();

    // Two-word program, table of reads.
    stream_q = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    run_stream("two_word", 1'b0);
    for (int i = 0; i < 7; i++) begin
      ce   = tab[i].ce;
      addr = tab[i].addr;
      #1;
      chk($sformatf("rd_tab%0d", i), inst, tab[i].exp);
    end

    // Reload with a byte offered: byte 01 must not become the header.
    pulse_reload(8'h01);
    chk("reload_rstn",  {31'b0, core_rst_n}, 32'h0);
    chk("reload_done",  {31'b0, done},       32'h0);
    chk("reload_ready", {31'b0, load_ready}, 32'h1);
    read_chk("reload_inst", 32'h0, 32'h0);
    stream_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    run_stream("after_reload", 1'b1);
    read_chk("rd_12345678", 32'h0, 32'h1234_5678);
    read_chk("rd_after_n",  32'h4, 32'h0);

    // Abandoned partial load, then a fresh one-word load.
    pulse_reload(8'h00);
    stream_q = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC};
    foreach (stream_q[i]) send_byte(stream_q[i], 1'b1);
    rst = 1'b0;
    load_valid = 1'b1; load_byte = 8'hDD;
    tick();
    rst = 1'b1; load_valid = 1'b0;
    read_chk("midrst_inst", 32'h0, 32'h0);
    chk("midrst_rstn", {31'b0, core_rst_n}, 32'h0);
    stream_q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_stream("deadbeef", 1'b1);
    read_chk("rd_deadbeef", 32'h0, 32'hDEAD_BEEF);
    ce = 1'b0;
    #1;
    chk("rd_ce0", inst, 32'h0);

    // Empty program.
    pulse_reload(8'h00);
    stream_q = '{8'h00, 8'h00};
    run_stream("empty", 1'b0);
    read_chk("rd_empty", 32'h0, 32'h0);

    // Full-capacity program (1024 words).
    pulse_reload(8'h00);
    stream_q = '{8'h04, 8'h00};
    for (int w = 0; w < 1024; w++) begin
      stream_q.push_back(8'hA5);
      stream_q.push_back(8'h00);
      stream_q.push_back(8'(w >> 8));
      stream_q.push_back(8'(w));
    end
    run_stream("full", 1'b0);
    read_chk("rd_full_first", 32'h0000_0000, 32'hA500_0000);
    read_chk("rd_full_mid",   32'h0000_0800, 32'hA500_0200);
    read_chk("rd_full_last",  32'h0000_0FFC, 32'hA500_03FF);
    read_chk("rd_full_above", 32'h0000_1000, 32'h0);

    // Oversized header goes to ERR and stays there.
    pulse_reload(8'h00);
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("err_flag",  {31'b0, load_err},   32'h1);
    chk("err_ready", {31'b0, load_ready}, 32'h0);
    chk("err_rstn",  {31'b0, core_rst_n}, 32'h0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      load_valid = 1'b1;
      load_byte  = 8'($urandom);
      reload     = (i == 50);
      tick();
      if (core_rst_n !== 1'b0 || load_ready !== 1'b0 || load_err !== 1'b1) bad++;
    end
    load_valid = 1'b0; reload = 1'b0;
    chk("err_hold_bad_cycles", bad, 32'h0);
    read_chk("err_inst", 32'h0, 32'h0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("err_cleared", {31'b0, load_err}, 32'h0);
    chk("err_rst_ready", {31'b0, load_ready}, 32'h1);

`ifdef LOADER_CHECKSUM_EN
    stream_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAB};
    foreach (stream_q[i]) send_byte(stream_q[i], 1'b1);
    chk("cks_good_rstn", {31'b0, core_rst_n}, 32'h1);
    read_chk("cks_good_inst", 32'h0, 32'h1122_3344);
    pulse_reload(8'h00);
    stream_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAC};
    foreach (stream_q[i]) send_byte(stream_q[i], 1'b0);
    chk("cks_bad_err",  {31'b0, load_err},   32'h1);
    chk("cks_bad_rstn", {31'b0, core_rst_n}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
INST_ROM_LOADER -- requirements
Module: inst_rom_loader

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, log2 of instruction-word capacity (1024 words).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-004 ce  input  1  core fetch enable, driven by core rom_ce_o.
REQ-005 addr  input  32  core fetch byte address, driven by core rom_addr_o.
REQ-006 inst  output  32  fetched instruction to core rom_data_i.
REQ-007 load_byte  input  8  loader data byte.
REQ-008 load_valid  input  1  load_byte valid.
REQ-009 load_ready  output  1  loader can accept a byte.
REQ-010 reload  input  1  single-cycle request to reload program.
REQ-011 core_rst_n  output  1  registered active-low reset for the core.
REQ-012 done  output  1  program loaded, core running.
REQ-013 load_err  output  1  load failed; sticky until rst.

Function
REQ-014 The block SHALL accept a byte on a rising edge only when load_valid and load_ready are both 1.
REQ-015 Stream format SHALL be: 2 header bytes giving word count N (big-endian, 16 bits), then 4*N data bytes, each word big-endian, written to word indices 0..N-1 in order.
REQ-016 States SHALL be HDR0, HDR1, DATA, CHK, RUN, ERR; load_ready = 1 in HDR0/HDR1/DATA/CHK, 0 in RUN/ERR.
REQ-017 HDR0 -> HDR1 on first header byte; HDR1 -> DATA if N in 1..2^DEPTH_LOG2, -> RUN (or CHK per REQ-030) if N = 0, -> ERR if N > 2^DEPTH_LOG2.
REQ-018 In DATA, the memory write SHALL occur on the edge accepting the 4th byte of a word; after word N-1 the state SHALL go to RUN (or CHK per REQ-030).
REQ-019 core_rst_n and done SHALL be 1 exactly when state is RUN, registered, so they rise the cycle after the final byte is accepted.
REQ-020 inst SHALL be combinational: mem[addr[DEPTH_LOG2+1:2]] when state = RUN, ce = 1, addr[31:DEPTH_LOG2+2] = 0 and word index < N; otherwise 32'h0 (NOP). addr[1:0] SHALL be ignored.
REQ-021 In RUN, reload = 1 SHALL move state to HDR0 next cycle, clear N, and drop core_rst_n/done in that same next cycle; reload SHALL be ignored in every other state.
REQ-022 ERR SHALL set load_err, hold core_rst_n = 0, and be left only by rst.
REQ-023 The byte/word counter SHALL be DEPTH_LOG2+2 bits wide, with no wrap possible inside a legal load.

Reset
REQ-024 On rst = 0: state = HDR0, N = 0, byte counter = 0, shift register = 0, load_err = 0, core_rst_n = 0, done = 0, checksum accumulator = 0.
REQ-025 Memory contents SHALL NOT be cleared; they SHALL be unreadable until reloaded because N = 0.
REQ-026 rst asserted mid-load SHALL abandon the partial load; bytes presented during reset SHALL NOT be accepted.

Configuration
REQ-027 Macro LOADER_CHECKSUM_EN SHALL select checksum support.
REQ-028 Without LOADER_CHECKSUM_EN, the CHK state SHALL be absent and the loader SHALL go directly to RUN after the last data byte (or after the header when N = 0).
REQ-029 With LOADER_CHECKSUM_EN, one extra byte SHALL follow the data bytes: the 8-bit modulo-256 sum of the header and data bytes.
REQ-030 With LOADER_CHECKSUM_EN, the loader SHALL enter CHK after the last data byte (or after the header when N = 0), then RUN on a matching checksum byte and ERR on a mismatching one.

Verification
REQ-031 Without macro, stream 00 02 24 01 00 05 00 00 00 00 -> core_rst_n rises 1 cycle after the last byte; addr 0 -> 24010005; addr 4 -> 0; addr 8 -> 0 (index >= N).
REQ-032 Header 04 01 with DEPTH_LOG2 = 10 -> ERR, load_err = 1, load_ready = 0, core_rst_n stays 0 through 100 further bytes.
REQ-033 rst pulsed after 3 data bytes, then valid 1-word load of DEADBEEF -> addr 0 -> DEADBEEF; no stale partial word visible.
REQ-034 In RUN, pulse reload with load_valid = 1 -> no byte consumed that cycle; next cycle core_rst_n = 0, inst = 0, load_ready = 1.
REQ-035 With LOADER_CHECKSUM_EN, stream 00 01 11 22 33 44 AB -> RUN; the same stream with final byte AC -> ERR and load_err = 1.
REQ-036 Under random load_valid gaps, ce = 0 or addr = 32'h0001_0000 -> inst = 0.
